pipe_wb: RTL and testbench
==========================

# pipe_wb

MEM/WB pipeline stage of the five-stage CPU, directly downstream of the data-memory stage. It registers the MEM-stage control and ALU result and accepts the synchronous data-RAM read word one cycle after the address. It aligns and extends load data, then drives the register-file write port and the WB forwarding path. Under stall, a one-entry hold buffer preserves the RAM read word, because the RAM output is not held.

## Interface
Parameters:
- DATA_W, 32, datapath and RAM word width
- REG_AW, 5, register-file address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold the WB stage contents
- flush  in  1  turn the WB stage into a bubble
- mem_valid  in  1  MEM stage holds a real instruction
- mem_wreg  in  1  instruction writes a register
- mem_m2reg  in  1  result comes from memory (load)
- mem_rn  in  REG_AW  destination register
- mem_alu  in  DATA_W  ALU result / effective address
- mem_ld_type  in  3  load kind (LW, LB, LBU, LH, LHU)
- ram_outdata  in  DATA_W  RAM read word, valid the cycle after the MEM address
- wb_we  out  1  register-file write enable
- wb_rn  out  REG_AW  write address
- wb_data  out  DATA_W  write data; also the forwarding value
- wb_misalign  out  1  current WB load is misaligned

## Operation
- Stage register S holds: valid, wreg, m2reg, rn, alu, ld_type.
- S loads from the mem_* inputs on each edge where !stall && !flush.
- flush=1 at an edge sets S.valid=0; all other S fields are don't-care. flush beats stall.
- Hold buffer (hold_vld, hold_data):
  - At an edge with stall=1 && hold_vld=0 && !flush: hold_data<=ram_outdata and hold_vld<=1.
  - At any edge with stall=0 or flush=1: hold_vld<=0.
- Load word: LW = hold_vld ? hold_data : ram_outdata.
- Byte offset off = S.alu[1:0]. Little-endian lanes: byte k = LW[8k+7:8k], half h = LW[16h+15:16h].
- Extraction:
  - LB and LBU select byte off. LB sign-extends; LBU zero-extends.
  - LH and LHU select half off[1]. LH sign-extends; LHU zero-extends.
  - LW passes the word unchanged.
- Misalignment: wb_misalign = S.valid && S.m2reg && ((LH|LHU with off[0]=1) || (LW with off≠0)).
- wb_data = S.m2reg ? extracted : S.alu.
- wb_we = S.valid && S.wreg && (S.rn≠0) && !wb_misalign.
- wb_rn = S.rn.
- wb_we is not gated by stall. A repeated write of the same value during a stall is idempotent.

## Timing
- Reset (rst=1 at an edge): S.valid=0, S.wreg=0, S.m2reg=0, S.rn=0, S.alu=0, S.ld_type=LW, hold_vld=0, hold_data=0.
- After reset: wb_we=0, wb_rn=0, wb_data=0, wb_misalign=0. rst beats flush and stall.
- Latency: an instruction in MEM during cycle n appears on the wb_* outputs throughout cycle n+1. wb_data for a load uses ram_outdata of cycle n+1 (RAM read latency 1).
- Outputs are combinational from S, the hold buffer and ram_outdata; there is no extra register.
- Stall lasting k cycles: the wb_* outputs stay constant for all k+1 cycles. From the second stall cycle on, the load word comes from hold_data.
- Stall release: at the first edge with stall=0, S advances and hold_vld clears in the same edge.
- Flush during stall: the bubble appears next cycle and the hold buffer is discarded.
- rst asserted mid-stall: the state fully clears with no residual hold data.

## Configuration
- PIPE_WB_SUBWORD_EN defined: the full LB/LBU/LH/LHU/LW extraction and misalignment check as described.
- Undefined:
  - mem_ld_type is ignored and every load is treated as LW.
  - wb_misalign is tied to 0.
  - wb_data = S.m2reg ? LW : S.alu.

## Structure
- Shared package pipe_pkg: DATA_W and REG_AW defaults, plus the 3-bit load-type encodings LD_LW=0, LD_LB=1, LD_LBU=2, LD_LH=3, LD_LHU=4.
- One sub-module: load_align. It is purely combinational and maps (LW word, off, ld_type) to (extracted, misalign). It is compiled only under PIPE_WB_SUBWORD_EN.

## Test plan
- Reset, then an ALU op (mem_wreg=1, mem_rn=5, mem_alu=32'h1234_5678): next cycle wb_we=1, wb_rn=5, wb_data=32'h1234_5678.
- LB with off=3 and ram_outdata=32'h80FF_0011: wb_data=32'hFFFF_FF80. Same case with LBU: 32'h0000_0080. LH with off=2: 32'hFFFF_80FF.
- LW to rn=0: wb_we=0. LH with off=1: wb_misalign=1 and wb_we=0.
- Load with ram_outdata=32'hCAFE_F00D, then stall held 3 cycles while ram_outdata changes to 32'h0: wb_data stays 32'hCAFE_F00D for all 4 cycles.
- stall=1 and flush=1 together: next cycle wb_we=0 and hold_vld=0. A following real instruction proceeds normally.
- rst asserted during a 2-cycle stall: next cycle all outputs are 0 and there is no stale hold data on the next load.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the WB pipeline stage: default widths and the
// load-type encodings carried down the pipe from decode.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_AW = 5;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ld_type_e;

endpackage

// File: rtl/pipe_wb_load_align.sv
// load_align: combinational byte/half/word extraction of a little-endian
// load word, plus detection of misaligned half/word accesses.
// Only built when PIPE_WB_SUBWORD_EN is defined.
`ifdef PIPE_WB_SUBWORD_EN
module load_align
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  ld_type_e          ld_type,
  output logic [DATA_W-1:0] extracted,
  output logic              misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    ext_byte = {{(DATA_W-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    ext_half = {{(DATA_W-16){sgn & h[15]}}, h};
  endfunction

  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = word[{off[1], 4'b0000} +: 16];

  // Select the lane for the load kind and flag accesses that straddle lanes
  always_comb begin
    extracted = word;
    misalign  = 1'b0;
    case (ld_type)
      LD_LB:   extracted = ext_byte(byte_sel, 1'b1);
      LD_LBU:  extracted = ext_byte(byte_sel, 1'b0);
      LD_LH: begin
        extracted = ext_half(half_sel, 1'b1);
        misalign  = off[0];
      end
      LD_LHU: begin
        extracted = ext_half(half_sel, 1'b0);
        misalign  = off[0];
      end
      default: misalign = (off != 2'b00);
    endcase
  end

endmodule
`endif

// File: rtl/pipe_wb.sv
// pipe_wb: MEM/WB stage. Registers MEM control and ALU result, merges the
// one-cycle-late RAM read word (held across stalls), and drives the
// register-file write port / WB forwarding value.
// Optional feature macro: PIPE_WB_SUBWORD_EN enables byte/half loads and the
// misalignment check; without it every load is a full word.
module pipe_wb
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_AW = PIPE_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [REG_AW-1:0] mem_rn,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [2:0]        mem_ld_type,
  input  logic [DATA_W-1:0] ram_outdata,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rn,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misalign
);

  logic              vld_p1;
  logic              wreg_p1;
  logic              m2reg_p1;
  logic [REG_AW-1:0] rn_p1;
  logic [DATA_W-1:0] alu_p1;
  ld_type_e          ld_type_p1;

  logic              hold_vld;
  logic [DATA_W-1:0] hold_data;

  logic [DATA_W-1:0] ld_word;
  logic [DATA_W-1:0] load_val;
  logic              misalign;

  // Stage register: flush inserts a bubble, stall freezes, otherwise advance
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      wreg_p1    <= 1'b0;
      m2reg_p1   <= 1'b0;
      rn_p1      <= '0;
      alu_p1     <= '0;
      ld_type_p1 <= LD_LW;
    end else if (flush) begin
      vld_p1     <= 1'b0;
    end else if (!stall) begin
      vld_p1     <= mem_valid;
      wreg_p1    <= mem_wreg;
      m2reg_p1   <= mem_m2reg;
      rn_p1      <= mem_rn;
      alu_p1     <= mem_alu;
      ld_type_p1 <= ld_type_e'(mem_ld_type);
    end
  end

  // Capture the RAM word on the first stalled edge; the RAM does not hold it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (stall && !flush) begin
      if (!hold_vld) begin
        hold_vld  <= 1'b1;
        hold_data <= ram_outdata;
      end
    end else begin
      hold_vld  <= 1'b0;
    end
  end

  assign ld_word = hold_vld ? hold_data : ram_outdata;

`ifdef PIPE_WB_SUBWORD_EN
  logic align_mis;

  load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .word      (ld_word),
    .off       (alu_p1[1:0]),
    .ld_type   (ld_type_p1),
    .extracted (load_val),
    .misalign  (align_mis)
  );

  assign misalign = vld_p1 && m2reg_p1 && align_mis;
`else
  logic unused_ld_type;

  assign unused_ld_type = ^ld_type_p1;
  assign load_val       = ld_word;
  assign misalign       = 1'b0;
`endif

  // Drive the write port; a repeated write while stalled is harmless
  always_comb begin
    wb_rn       = rn_p1;
    wb_data     = m2reg_p1 ? load_val : alu_p1;
    wb_misalign = misalign;
    wb_we       = vld_p1 && wreg_p1 && (rn_p1 != '0) && !misalign;
  end

endmodule

// File: tb/tb_pipe_wb.sv
// Self-checking bench for pipe_wb: a one-deep scoreboard holds the expected
// WB outputs for the instruction currently in the stage.
module tb_pipe_wb;
  import pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic [4:0]  mem_rn;
  logic [31:0] mem_alu;
  logic [2:0]  mem_ld_type;
  logic [31:0] ram_outdata;
  logic        wb_we;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;
  logic        wb_misalign;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rn;
    logic [31:0] data;
    logic        mis;
    logic        full;   // rn/data are meaningful (not a flushed bubble)
  } exp_t;

  exp_t sb[$];

  pipe_wb #(
    .DATA_W (32),
    .REG_AW (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_wreg    (mem_wreg),
    .mem_m2reg   (mem_m2reg),
    .mem_rn      (mem_rn),
    .mem_alu     (mem_alu),
    .mem_ld_type (mem_ld_type),
    .ram_outdata (ram_outdata),
    .wb_we       (wb_we),
    .wb_rn       (wb_rn),
    .wb_data     (wb_data),
    .wb_misalign (wb_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference result for one instruction given the word the RAM will return
  function automatic exp_t model(input logic v, input logic w, input logic m2,
                                 input logic [4:0] rn, input logic [31:0] alu,
                                 input logic [2:0] ldt, input logic [31:0] ldw);
    exp_t        e;
    logic [31:0] ext;
    logic        mis;
    logic [7:0]  b;
    logic [15:0] h;
    ext = ldw;
    mis = 1'b0;
`ifdef PIPE_WB_SUBWORD_EN
    case (alu[1:0])
      2'd0: b = ldw[7:0];
      2'd1: b = ldw[15:8];
      2'd2: b = ldw[23:16];
      default: b = ldw[31:24];
    endcase
    h = alu[1] ? ldw[31:16] : ldw[15:0];
    if (ldt == LD_LB)       ext = {{24{b[7]}}, b};
    else if (ldt == LD_LBU) ext = {24'h0, b};
    else if (ldt == LD_LH)  ext = {{16{h[15]}}, h};
    else if (ldt == LD_LHU) ext = {16'h0, h};
    if ((ldt == LD_LH || ldt == LD_LHU) && alu[0]) mis = m2 & v;
    if (ldt == LD_LW && alu[1:0] != 2'd0)          mis = m2 & v;
`else
    b = 8'h0;
    h = 16'h0;
`endif
    e.data = m2 ? ext : alu;
    e.mis  = mis;
    e.we   = v && w && (rn != 5'd0) && !mis;
    e.rn   = rn;
    e.full = 1'b1;
    return e;
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, then update scoreboard
  task automatic cyc(input logic v, input logic w, input logic m2,
                     input logic [4:0] rn, input logic [31:0] alu,
                     input logic [2:0] ldt, input logic [31:0] ldw,
                     input logic [31:0] ram, input logic st, input logic fl,
                     input logic rs);
    exp_t e;
    mem_valid   = v;
    mem_wreg    = w;
    mem_m2reg   = m2;
    mem_rn      = rn;
    mem_alu     = alu;
    mem_ld_type = ldt;
    ram_outdata = ram;
    stall       = st;
    flush       = fl;
    rst         = rs;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb[0];
      check("wb_we", {31'h0, wb_we}, {31'h0, e.we});
      check("wb_misalign", {31'h0, wb_misalign}, {31'h0, e.mis});
      if (e.full) begin
        check("wb_rn", {27'h0, wb_rn}, {27'h0, e.rn});
        check("wb_data", wb_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    if (rs) begin
      sb.delete();
      e = '{we: 1'b0, rn: 5'd0, data: 32'h0, mis: 1'b0, full: 1'b1};
      sb.push_back(e);
    end else if (fl) begin
      sb.delete();
      e = '{we: 1'b0, rn: 5'd0, data: 32'h0, mis: 1'b0, full: 1'b0};
      sb.push_back(e);
    end else if (!st) begin
      sb.delete();
      sb.push_back(model(v, w, m2, rn, alu, ldt, ldw));
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_wreg = 1'b0; mem_m2reg = 1'b0; mem_rn = '0;
    mem_alu = '0; mem_ld_type = LD_LW; ram_outdata = '0;

    // reset and reset state
    cyc(0, 0, 0, 5'd0,  32'h0,         LD_LW,  32'h0,         32'h0,         0, 0, 1);
    cyc(0, 0, 0, 5'd0,  32'h0,         LD_LW,  32'h0,         32'h0,         0, 0, 1);
    // ALU op, then a run of sub-word loads
    cyc(1, 1, 0, 5'd5,  32'h1234_5678, LD_LW,  32'h0,         32'h0,         0, 0, 0);
    cyc(1, 1, 1, 5'd7,  32'h0000_0103, LD_LB,  32'h80FF_0011, 32'h0,         0, 0, 0);
    cyc(1, 1, 1, 5'd8,  32'h0000_0107, LD_LBU, 32'h80FF_0011, 32'h80FF_0011, 0, 0, 0);
    cyc(1, 1, 1, 5'd9,  32'h0000_0102, LD_LH,  32'h80FF_0011, 32'h80FF_0011, 0, 0, 0);
    cyc(1, 1, 1, 5'd0,  32'h0000_0200, LD_LW,  32'hDEAD_BEEF, 32'h80FF_0011, 0, 0, 0);
    cyc(1, 1, 1, 5'd10, 32'h0000_0201, LD_LH,  32'h1234_8765, 32'hDEAD_BEEF, 0, 0, 0);
    cyc(1, 1, 1, 5'd11, 32'h0000_0202, LD_LHU, 32'h1234_8765, 32'h1234_8765, 0, 0, 0);
    cyc(1, 1, 1, 5'd12, 32'h0000_0101, LD_LB,  32'h0000_A500, 32'h1234_8765, 0, 0, 0);
    cyc(1, 1, 1, 5'd13, 32'h0000_0300, LD_LW,  32'hCAFE_F00D, 32'h0000_A500, 0, 0, 0);
    // 3-cycle stall with the RAM output going to zero
    cyc(1, 1, 0, 5'd14, 32'h0000_0055, LD_LW,  32'h0,         32'hCAFE_F00D, 1, 0, 0);
    cyc(1, 1, 0, 5'd14, 32'h0000_0055, LD_LW,  32'h0,         32'h0,         1, 0, 0);
    cyc(1, 1, 0, 5'd14, 32'h0000_0055, LD_LW,  32'h0,         32'h0,         1, 0, 0);
    cyc(1, 1, 0, 5'd14, 32'h0000_0055, LD_LW,  32'h0,         32'h0,         0, 0, 0);
    // stall, then stall+flush; the next load must not see the held word
    cyc(1, 1, 1, 5'd15, 32'h0000_0400, LD_LW,  32'h1111_2222, 32'h0,         0, 0, 0);
    cyc(1, 1, 0, 5'd16, 32'h0000_0066, LD_LW,  32'h0,         32'h1111_2222, 1, 0, 0);
    cyc(1, 1, 0, 5'd16, 32'h0000_0066, LD_LW,  32'h0,         32'h0,         1, 1, 0);
    cyc(1, 1, 1, 5'd17, 32'h0000_0500, LD_LW,  32'h3333_4444, 32'h0,         0, 0, 0);
    cyc(1, 1, 0, 5'd18, 32'h0000_0077, LD_LW,  32'h0,         32'h3333_4444, 0, 0, 0);
    // reset in the middle of a 2-cycle stall
    cyc(1, 1, 1, 5'd19, 32'h0000_0600, LD_LW,  32'hABCD_0123, 32'h0,         0, 0, 0);
    cyc(0, 0, 0, 5'd0,  32'h0,         LD_LW,  32'h0,         32'hABCD_0123, 1, 0, 0);
    cyc(0, 0, 0, 5'd0,  32'h0,         LD_LW,  32'h0,         32'h0,         1, 0, 1);
    cyc(1, 1, 1, 5'd20, 32'h0000_0700, LD_LW,  32'h5A5A_5A5A, 32'h0,         0, 0, 0);
    cyc(0, 0, 0, 5'd0,  32'h0,         LD_LW,  32'h0,         32'h5A5A_5A5A, 0, 0, 0);
    cyc(0, 0, 0, 5'd0,  32'h0,         LD_LW,  32'h0,         32'h0,         0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
